// File: rtl/leela_mc_arb.sv
// Wishbone N-to-1 arbiter in front of a memory controller: fixed or round-robin
// selection, grant held for the whole cycle, stalled-slave timeout with abort.
module leela_mc_arb #(
    parameter int NPORTS  = 3,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int RR      = 1,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NPORTS*AW-1:0]       m_adr_i,
    input  logic [NPORTS*DW-1:0]       m_dat_i,
    input  logic [NPORTS*(DW/8)-1:0]   m_sel_i,
    input  logic [NPORTS-1:0]          m_we_i,
    input  logic [NPORTS-1:0]          m_stb_i,
    input  logic [NPORTS-1:0]          m_cyc_i,
    input  logic [NPORTS*3-1:0]        m_cti_i,
    input  logic [NPORTS*2-1:0]        m_bte_i,
    output logic [DW-1:0]              m_dat_o,
    output logic [NPORTS-1:0]          m_ack_o,
    output logic [NPORTS-1:0]          m_err_o,
    output logic [AW-1:0]              s_adr_o,
    output logic [DW-1:0]              s_dat_o,
    output logic [DW/8-1:0]            s_sel_o,
    output logic                       s_we_o,
    output logic                       s_stb_o,
    output logic                       s_cyc_o,
    output logic [2:0]                 s_cti_o,
    output logic [1:0]                 s_bte_o,
    input  logic [DW-1:0]              s_dat_i,
    input  logic                       s_ack_i,
    input  logic                       s_err_i,
    output logic [NPORTS-1:0]          gnt_o,
    output logic                       tmo_o
);

    localparam int SW = DW/8;
    localparam int IW = $clog2(NPORTS);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] ABORT = 2'd2;

    logic [1:0]        state;
    logic [IW-1:0]     gidx, last, start, nxt_idx;
    logic [NPORTS-1:0] gnt, onehot;
    logic              found, in_grant, tmo_hit;
    logic [CW-1:0]     cnt;

    logic [AW-1:0] adr_a [NPORTS];
    logic [DW-1:0] dat_a [NPORTS];
    logic [SW-1:0] sel_a [NPORTS];
    logic [2:0]    cti_a [NPORTS];
    logic [1:0]    bte_a [NPORTS];

    for (genvar k = 0; k < NPORTS; k++) begin : g_port
        assign adr_a[k]   = m_adr_i[k*AW +: AW];
        assign dat_a[k]   = m_dat_i[k*DW +: DW];
        assign sel_a[k]   = m_sel_i[k*SW +: SW];
        assign cti_a[k]   = m_cti_i[k*3 +: 3];
        assign bte_a[k]   = m_bte_i[k*2 +: 2];
        // a timeout abort takes precedence over a coincident slave ack
        assign m_ack_o[k] = in_grant && (gidx == IW'(k)) && s_ack_i && !tmo_hit;
        assign m_err_o[k] = in_grant && (gidx == IW'(k)) && (s_err_i || tmo_hit);
    end

    // rotating search: start one past the last grantee (or at 0 for fixed priority)
    always_comb begin
        logic [IW:0] j;
        start   = '0;
        if (RR != 0)
            start = (last == IW'(NPORTS-1)) ? '0 : last + 1'b1;
        nxt_idx = '0;
        found   = 1'b0;
        j       = '0;
        for (int i = 0; i < NPORTS; i++) begin
            j = {1'b0, start} + (IW+1)'(i);
            if (j >= (IW+1)'(NPORTS))
                j = j - (IW+1)'(NPORTS);
            if (!found && m_cyc_i[j[IW-1:0]]) begin
                found   = 1'b1;
                nxt_idx = j[IW-1:0];
            end
        end
        onehot          = '0;
        onehot[nxt_idx] = 1'b1;
    end

    assign in_grant = (state == GRANT);
    assign tmo_hit  = (TIMEOUT != 0) && in_grant && (cnt == TMAX);
    assign tmo_o    = tmo_hit;
    assign gnt_o    = gnt;
    assign m_dat_o  = s_dat_i;

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_stb_o = 1'b0;
        s_cyc_o = 1'b0;
        s_cti_o = '0;
        s_bte_o = '0;
        if (in_grant) begin
            s_adr_o = adr_a[gidx];
            s_dat_o = dat_a[gidx];
            s_sel_o = sel_a[gidx];
            s_we_o  = m_we_i[gidx];
            s_stb_o = m_stb_i[gidx];
            s_cyc_o = m_cyc_i[gidx];
            s_cti_o = cti_a[gidx];
            s_bte_o = bte_a[gidx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            gnt   <= '0;
            gidx  <= '0;
            last  <= IW'(NPORTS-1);
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (found) begin
                        state <= GRANT;
                        gidx  <= nxt_idx;
                        last  <= nxt_idx;
                        gnt   <= onehot;
                    end
                end
                GRANT: begin
                    if (!m_cyc_i[gidx]) begin
                        state <= IDLE;
                        gnt   <= '0;
                        cnt   <= '0;
                    end else if (tmo_hit) begin
                        state <= ABORT;
                        cnt   <= '0;
                    end else if (s_ack_i || s_err_i) begin
                        cnt <= '0;
                    end else if (s_stb_o && cnt != TMAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ABORT: begin
                    cnt <= '0;
                    if (!m_cyc_i[gidx]) begin
                        state <= IDLE;
                        gnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_leela_mc_arb.sv
// Bench for leela_mc_arb: a round-robin and a fixed-priority instance share
// master stimulus; expected grants/acks/aborts are queued and popped on arrival.
module tb_leela_mc_arb;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW/8;

    logic clk = 1'b0;
    logic rst;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat;
    logic [N*SW-1:0] m_sel;
    logic [N-1:0]    m_we, m_stb, m_cyc;
    logic [N*3-1:0]  m_cti;
    logic [N*2-1:0]  m_bte;
    logic [DW-1:0]   s_dat_i;
    logic            ack_en, ack_force, err_force;

    logic [DW-1:0] r_dat_o, f_dat_o;
    logic [N-1:0]  r_ack, r_err, f_ack, f_err, r_gnt, f_gnt;
    logic [AW-1:0] r_s_adr, f_s_adr;
    logic [DW-1:0] r_s_dat, f_s_dat;
    logic [SW-1:0] r_s_sel, f_s_sel;
    logic          r_s_we, r_s_stb, r_s_cyc, f_s_we, f_s_stb, f_s_cyc;
    logic [2:0]    r_s_cti, f_s_cti;
    logic [1:0]    r_s_bte, f_s_bte;
    logic          r_tmo, f_tmo;
    logic          r_s_ack, f_s_ack;

    // slave model: zero-wait ack while enabled, or a forced (possibly late) ack
    assign r_s_ack = ack_force | (ack_en & r_s_stb);
    assign f_s_ack = ack_force | (ack_en & f_s_stb);

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    leela_mc_arb #(.NPORTS(N), .AW(AW), .DW(DW), .RR(1), .TIMEOUT(8)) u_rr (
        .clk(clk), .rst(rst),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
        .m_stb_i(m_stb), .m_cyc_i(m_cyc), .m_cti_i(m_cti), .m_bte_i(m_bte),
        .m_dat_o(r_dat_o), .m_ack_o(r_ack), .m_err_o(r_err),
        .s_adr_o(r_s_adr), .s_dat_o(r_s_dat), .s_sel_o(r_s_sel), .s_we_o(r_s_we),
        .s_stb_o(r_s_stb), .s_cyc_o(r_s_cyc), .s_cti_o(r_s_cti), .s_bte_o(r_s_bte),
        .s_dat_i(s_dat_i), .s_ack_i(r_s_ack), .s_err_i(err_force),
        .gnt_o(r_gnt), .tmo_o(r_tmo)
    );

    leela_mc_arb #(.NPORTS(N), .AW(AW), .DW(DW), .RR(0), .TIMEOUT(8)) u_fp (
        .clk(clk), .rst(rst),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
        .m_stb_i(m_stb), .m_cyc_i(m_cyc), .m_cti_i(m_cti), .m_bte_i(m_bte),
        .m_dat_o(f_dat_o), .m_ack_o(f_ack), .m_err_o(f_err),
        .s_adr_o(f_s_adr), .s_dat_o(f_s_dat), .s_sel_o(f_s_sel), .s_we_o(f_s_we),
        .s_stb_o(f_s_stb), .s_cyc_o(f_s_cyc), .s_cti_o(f_s_cti), .s_bte_o(f_s_bte),
        .s_dat_i(s_dat_i), .s_ack_i(f_s_ack), .s_err_i(err_force),
        .gnt_o(f_gnt), .tmo_o(f_tmo)
    );

    task automatic set_port(input int k, input logic cyc, input logic stb, input logic we,
                            input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                            input logic [SW-1:0] sel, input logic [2:0] cti);
        m_cyc[k] = cyc;
        m_stb[k] = stb;
        m_we[k]  = we;
        m_adr[k*AW +: AW] = adr;
        m_dat[k*DW +: DW] = dat;
        m_sel[k*SW +: SW] = sel;
        m_cti[k*3 +: 3]   = cti;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_stb = '0; m_cyc = '0;
        m_cti = '0; m_bte = '0; s_dat_i = '0;
        ack_en = 1'b0; ack_force = 1'b0; err_force = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m_cyc = '1; m_stb = '1; ack_force = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (r_gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt_rr: got %b want 000", r_gnt); end
        checks++; if (f_gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt_fp: got %b want 000", f_gnt); end
        checks++; if (r_tmo !== 1'b0) begin errors++; $display("FAIL reset_tmo: got %b want 0", r_tmo); end
        checks++; if ({r_s_cyc, r_s_stb, f_s_cyc} !== 3'b000) begin errors++; $display("FAIL reset_s_cyc: got %b want 000", {r_s_cyc, r_s_stb, f_s_cyc}); end
        checks++; if ({r_ack, r_err} !== 6'b0) begin errors++; $display("FAIL reset_ack_err: got %b want 000000", {r_ack, r_err}); end
        do_reset();
    endtask

    task automatic run_single_reads(input bit fp);
        logic [2:0] gq[$];
        logic [2:0] g, a, exp, prev;
        bit drop[N];
        int idle, ngr;
        do_reset();
        ack_en = 1'b1;
        for (int k = 0; k < 4; k++) gq.push_back(fp ? 3'b001 : (3'b001 << (k % 3)));
        for (int k = 0; k < N; k++) begin set_port(k, 1, 1, 0, '0, '0, '0, 3'b000); drop[k] = 0; end
        prev = '0; idle = 0; ngr = 0;
        for (int c = 0; c < 40 && gq.size() > 0; c++) begin
            @(negedge clk);
            g = fp ? f_gnt : r_gnt;
            a = fp ? f_ack : r_ack;
            if (g != 0 && prev == 0) begin
                exp = gq.pop_front();
                checks++; if (g !== exp) begin errors++; $display("FAIL grant_seq fp=%0d: got %b want %b", fp, g, exp); end
                if (ngr > 0) begin
                    checks++; if (idle !== 1) begin errors++; $display("FAIL idle_gap fp=%0d: got %0d want 1", fp, idle); end
                end
                ngr++;
                idle = 0;
            end
            if (g == 0) idle++;
            if (g != 0) begin
                checks++; if (a !== g) begin errors++; $display("FAIL ack_route fp=%0d: got %b want %b", fp, a, g); end
            end
            for (int k = 0; k < N; k++) begin
                if (drop[k]) begin m_cyc[k] = 1'b1; m_stb[k] = 1'b1; drop[k] = 0; end
                else if (a[k]) begin m_cyc[k] = 1'b0; m_stb[k] = 1'b0; drop[k] = 1; end
            end
            prev = g;
        end
        checks++; if (gq.size() != 0) begin errors++; $display("FAIL grant_budget fp=%0d: got %0d pending want 0", fp, gq.size()); end
    endtask

    task automatic test_round_robin();
        run_single_reads(1'b0);
    endtask

    task automatic test_fixed_priority();
        run_single_reads(1'b1);
    endtask

    task automatic test_burst();
        logic [2:0] aq[$];
        logic [2:0] exp;
        int beats;
        do_reset();
        ack_en = 1'b1;
        repeat (4) aq.push_back(3'b010);
        set_port(1, 1, 1, 0, 32'h0000_1000, '0, 4'hF, 3'b010);
        m_bte[2 +: 2] = 2'b00;
        beats = 0;
        for (int c = 0; c < 10 && beats < 4; c++) begin
            @(negedge clk);
            checks++; if (r_gnt !== 3'b010) begin errors++; $display("FAIL burst_gnt: got %b want 010", r_gnt); end
            if (r_ack != 0) begin
                if (aq.size() == 0) begin
                    checks++; errors++; $display("FAIL burst_extra_ack: got %b want none", r_ack);
                end else begin
                    exp = aq.pop_front();
                    checks++; if (r_ack !== exp) begin errors++; $display("FAIL burst_ack: got %b want %b", r_ack, exp); end
                end
                beats++;
                if (beats == 1) begin m_cyc[0] = 1'b1; m_stb[0] = 1'b1; end
                if (beats == 3) m_cti[3 +: 3] = 3'b111;
                if (beats == 4) begin m_cyc[1] = 1'b0; m_stb[1] = 1'b0; end
            end
        end
        checks++; if (aq.size() != 0) begin errors++; $display("FAIL burst_acks: got %0d pending want 0", aq.size()); end
        @(negedge clk);
        checks++; if (r_gnt !== 3'b000) begin errors++; $display("FAIL burst_dead_cycle: got %b want 000", r_gnt); end
        @(negedge clk);
        checks++; if (r_gnt !== 3'b001) begin errors++; $display("FAIL burst_next_gnt: got %b want 001", r_gnt); end
    endtask

    task automatic test_timeout();
        int tq[$];
        int exp_c;
        bit seen;
        do_reset();
        tq.push_back(9);
        set_port(2, 1, 1, 0, 32'h0000_0040, '0, 4'hF, 3'b000);
        seen = 0;
        for (int c = 1; c <= 14 && !seen; c++) begin
            @(negedge clk);
            if (r_tmo || r_err != 0) begin
                seen = 1;
                exp_c = (tq.size() > 0) ? tq.pop_front() : -1;
                checks++; if (c !== exp_c) begin errors++; $display("FAIL tmo_cycle: got %0d want %0d", c, exp_c); end
                checks++; if ({r_tmo, r_err} !== 4'b1100) begin errors++; $display("FAIL tmo_err: got %b want 1100", {r_tmo, r_err}); end
            end
        end
        checks++; if (tq.size() != 0) begin errors++; $display("FAIL tmo_budget: got %0d pending want 0", tq.size()); end
        @(negedge clk);
        checks++; if ({r_s_cyc, r_s_stb, r_tmo, r_err} !== 6'b0) begin errors++; $display("FAIL abort_outputs: got %b want 000000", {r_s_cyc, r_s_stb, r_tmo, r_err}); end
        checks++; if (r_gnt !== 3'b100) begin errors++; $display("FAIL abort_gnt: got %b want 100", r_gnt); end
        ack_force = 1'b1;
        @(negedge clk);
        checks++; if ({r_ack, r_err} !== 6'b0) begin errors++; $display("FAIL late_ack_abort: got %b want 000000", {r_ack, r_err}); end
        m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
        @(negedge clk);
        checks++; if ({r_gnt, r_ack} !== 6'b0) begin errors++; $display("FAIL late_ack_idle: got %b want 000000", {r_gnt, r_ack}); end
        ack_force = 1'b0;
    endtask

    task automatic test_reset_burst();
        do_reset();
        ack_en = 1'b1;
        set_port(1, 1, 1, 0, 32'h0000_2000, '0, 4'hF, 3'b010);
        @(negedge clk);
        checks++; if (r_ack !== 3'b010) begin errors++; $display("FAIL rb_beat1: got %b want 010", r_ack); end
        @(negedge clk);
        checks++; if (r_ack !== 3'b010) begin errors++; $display("FAIL rb_beat2: got %b want 010", r_ack); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({r_s_cyc, r_s_stb, r_gnt} !== 5'b0) begin errors++; $display("FAIL rb_after_reset: got %b want 00000", {r_s_cyc, r_s_stb, r_gnt}); end
        checks++; if ({r_ack, r_err} !== 6'b0) begin errors++; $display("FAIL rb_no_ack: got %b want 000000", {r_ack, r_err}); end
        rst = 1'b1;
        m_cyc = '0; m_stb = '0;
        set_port(2, 1, 1, 0, 32'h0000_3000, '0, 4'hF, 3'b000);
        @(negedge clk);
        checks++; if (r_gnt !== 3'b100) begin errors++; $display("FAIL rb_regrant: got %b want 100", r_gnt); end
    endtask

    task automatic test_write();
        do_reset();
        set_port(0, 0, 0, 1, 32'h1111_0000, 32'h1234_5678, 4'h3, 3'b010);
        set_port(2, 0, 0, 1, 32'h2222_0000, 32'h8765_4321, 4'hC, 3'b111);
        set_port(1, 1, 1, 1, 32'h0020_0010, 32'hDEAD_BEEF, 4'hF, 3'b000);
        m_bte = 6'b11_01_10;
        s_dat_i = 32'hCAFE_F00D;
        @(negedge clk);
        checks++; if (r_s_adr !== 32'h0020_0010) begin errors++; $display("FAIL wr_adr: got %h want 00200010", r_s_adr); end
        checks++; if (r_s_dat !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_dat: got %h want deadbeef", r_s_dat); end
        checks++; if ({r_s_sel, r_s_we, r_s_cyc, r_s_stb} !== 7'b1111_111) begin errors++; $display("FAIL wr_ctl: got %b want 1111111", {r_s_sel, r_s_we, r_s_cyc, r_s_stb}); end
        checks++; if ({r_s_cti, r_s_bte, r_gnt} !== 8'b000_01_010) begin errors++; $display("FAIL wr_cti_bte_gnt: got %b want 00001010", {r_s_cti, r_s_bte, r_gnt}); end
        checks++; if ({r_dat_o, f_dat_o} !== {2{32'hCAFE_F00D}}) begin errors++; $display("FAIL rd_bcast: got %h want cafef00dcafef00d", {r_dat_o, f_dat_o}); end
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        @(negedge clk);
        checks++; if ({r_s_adr, r_s_dat} !== 64'b0) begin errors++; $display("FAIL wr_release_data: got %h want 0", {r_s_adr, r_s_dat}); end
        checks++; if ({r_s_sel, r_s_we, r_s_cyc, r_s_stb, r_s_cti, r_s_bte} !== 12'b0) begin errors++; $display("FAIL wr_release_ctl: got %b want 0", {r_s_sel, r_s_we, r_s_cyc, r_s_stb, r_s_cti, r_s_bte}); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        test_reset();
        test_round_robin();
        test_fixed_priority();
        test_burst();
        test_timeout();
        test_reset_burst();
        test_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/leela_mc_arb.md
LEELA_MC_ARB -- requirements
Module: leela_mc_arb

Interface
REQ-001 Parameters SHALL be:
- NPORTS, default 3: number of Wishbone master ports (2..8).
- AW, default 32: address width.
- DW, default 32: data width; select width is DW/8.
- RR, default 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
- TIMEOUT, default 255: cycles with stb high and no ack/err before abort; 0 disables the timeout.

REQ-002 Ports SHALL be:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- m_adr_i  in  NPORTS*AW  master addresses, port k at [k*AW +: AW].
- m_dat_i  in  NPORTS*DW  master write data.
- m_sel_i  in  NPORTS*DW/8  byte selects.
- m_we_i / m_stb_i / m_cyc_i  in  NPORTS each  per-port control.
- m_cti_i  in  NPORTS*3  cycle type; m_bte_i  in  NPORTS*2  burst type.
- m_dat_o  out  DW  read data, broadcast to all ports.
- m_ack_o / m_err_o  out  NPORTS each  per-port termination.
- s_adr_o  out  AW; s_dat_o  out  DW; s_sel_o  out  DW/8; s_we_o, s_stb_o, s_cyc_o  out  1; s_cti_o  out  3; s_bte_o  out  2: downstream (memory controller) request.
- s_dat_i  in  DW; s_ack_i, s_err_i  in  1: downstream response.
- gnt_o  out  NPORTS  registered one-hot grant (all-zero when idle).
- tmo_o  out  1  one-cycle pulse on timeout abort.

Function
REQ-003 The state machine SHALL have three states: IDLE, GRANT, ABORT.

REQ-004 In IDLE with any m_cyc_i high, the arbiter SHALL register a one-hot grant and enter GRANT at the next edge (one-cycle arbitration latency); with no m_cyc_i high it SHALL stay in IDLE.

REQ-005 When RR=0, the lowest-index requesting port SHALL win.

REQ-006 When RR=1, the search SHALL start at (last grantee + 1) mod NPORTS; after reset, port 0 SHALL be first in the search.

REQ-007 In GRANT, all s_* request outputs SHALL combinationally follow the granted port, with s_cyc_o = m_cyc_i[g] and s_stb_o = m_stb_i[g].

REQ-008 In GRANT, m_ack_o[g] SHALL equal s_ack_i and m_err_o[g] SHALL equal s_err_i; every non-granted port SHALL see ack=0 and err=0.

REQ-009 The grant SHALL be held while m_cyc_i[g] is high, so bursts (cti 010 through 111) are never split or preempted.

REQ-010 When m_cyc_i[g] falls, the arbiter SHALL return to IDLE at the next edge; one dead cycle SHALL separate consecutive grants, with no same-cycle regrant.

REQ-011 Outside GRANT, s_cyc_o, s_stb_o and s_we_o SHALL be 0, and s_adr_o, s_dat_o, s_sel_o, s_cti_o and s_bte_o SHALL be 0.

REQ-012 The timeout counter SHALL behave as follows:
- increment each GRANT cycle with s_stb_o=1 and s_ack_i=0 and s_err_i=0;
- clear on ack, on err, and on leaving GRANT;
- width clog2(TIMEOUT+1); never wraps.

REQ-013 When the counter reaches TIMEOUT (TIMEOUT>0), the arbiter SHALL:
- in that cycle, drive m_err_o[g]=1 and tmo_o=1;
- at the next edge, enter ABORT.

REQ-014 In ABORT, s_cyc_o and s_stb_o SHALL be 0 and m_err_o SHALL be 0; the arbiter SHALL hold gnt_o and stay in ABORT until m_cyc_i[g]=0, then go to IDLE.

REQ-015 m_dat_o SHALL equal s_dat_i unconditionally.

REQ-016 A late s_ack_i arriving in ABORT or IDLE SHALL be ignored and SHALL NOT reach any master.

REQ-017 If a master drops stb but holds cyc, it SHALL keep the grant and the timeout counter SHALL not advance.

Reset
REQ-018 While rst=0 at a clock edge, the block SHALL enter IDLE; gnt_o=0, tmo_o=0, timeout counter=0, and the RR pointer SHALL make port 0 first in the search.

REQ-019 Reset asserted mid-burst SHALL deassert s_cyc_o, s_stb_o and all m_ack_o/m_err_o after that edge, with no further ack forwarded.

REQ-020 All outputs derived from state SHALL be at their reset values in the first cycle after reset is released.

Verification
REQ-021 The bench SHALL cover, with NPORTS=3 and TIMEOUT=8 unless stated:
- RR=1; ports 0, 1, 2 hold cyc continuously, each doing single reads acked in 1 cycle -> gnt_o sequence 001, 010, 100, 001, with one IDLE cycle between grants.
- RR=0; same stimulus -> port 0 granted every time; ports 1 and 2 never see ack.
- Port 1 does a 4-beat incrementing burst (cti 010,010,010,111) while port 0 raises cyc mid-burst -> all 4 acks go to port 1, gnt_o stays 010 throughout, and port 0 is granted 2 cycles after port 1 drops cyc.
- Port 2 stb with s_ack_i held 0 -> m_err_o[2] and tmo_o pulse exactly 8 GRANT cycles after stb, s_cyc_o=0 the next cycle, and a late s_ack_i is not forwarded.
- rst=0 asserted during beat 2 of a burst -> s_cyc_o=0 and gnt_o=000 after the edge; after release, a request from port 2 alone is granted with gnt_o=100.
- Write on port 1 with adr=0x0020_0010, dat=0xDEADBEEF, sel=0xF -> s_* outputs reproduce these values exactly while granted, and are 0 after release.
